// File: rtl/sram_arb_pkg.sv
`default_nettype none
// sram_arb_pkg -- owner-state encoding and SRAM width constants shared with sram_arbiter. rev 1.0
package sram_arb_pkg;

   localparam int SRAM_DW  = 32;
   localparam int SRAM_BEW = SRAM_DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD_I = 2'd1,
      ST_RD_D = 2'd2
   } arb_state_e;

   // A data access with no byte enables set is a load.
   function automatic logic is_read(input logic [SRAM_BEW-1:0] wen);
      return (wen == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// sram_arbiter -- instruction/data arbiter for one shared synchronous SRAM; data wins contention.
// Define SRAM_ARB_FAIR_EN to bound instruction starvation at STARVE_MAX data grants. rev 1.0
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                i_req,
   input  logic [AW-1:0]       i_addr,
   output logic                i_ack,
   output logic                i_rvalid,
   output logic [SRAM_DW-1:0]  i_rdata,
   input  logic                d_req,
   input  logic [SRAM_BEW-1:0] d_wen,
   input  logic [AW-1:0]       d_addr,
   input  logic [SRAM_DW-1:0]  d_wdata,
   output logic                d_ack,
   output logic                d_rvalid,
   output logic [SRAM_DW-1:0]  d_rdata,
   output logic                sram_en,
   output logic [SRAM_BEW-1:0] sram_wen,
   output logic [AW-1:0]       sram_addr,
   output logic [SRAM_DW-1:0]  sram_wdata,
   input  logic [SRAM_DW-1:0]  sram_rdata
);

   arb_state_e state_q, state_d;
   logic       grant_i, grant_d;
   logic       i_turn;

   // Grants are qualified by resetn so every output reads 0 while reset is held.
   always_comb begin
      grant_d = resetn && d_req && !i_turn;
      grant_i = resetn && i_req && !grant_d;
   end

`ifdef SRAM_ARB_FAIR_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign i_turn = i_req && (cnt_q >= CNT_W'(STARVE_MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (!i_req || grant_i) begin
         cnt_d = '0;
      end else if (grant_d && (cnt_q < CNT_W'(STARVE_MAX))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic [31:0] unused_starve;

   assign i_turn        = 1'b0;
   assign unused_starve = 32'(STARVE_MAX);
`endif

   // Owner state records whose read data the SRAM presents next cycle.
   always_comb begin
      state_d = ST_IDLE;
      if (grant_i) begin
         state_d = ST_RD_I;
      end else if (grant_d && is_read(d_wen)) begin
         state_d = ST_RD_D;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      i_ack      = grant_i;
      d_ack      = grant_d;
      sram_en    = grant_i || grant_d;
      sram_wen   = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (grant_d) begin
         sram_wen   = d_wen;
         sram_addr  = d_addr;
         sram_wdata = d_wdata;
      end else if (grant_i) begin
         sram_addr  = i_addr;
      end
   end

   always_comb begin
      i_rvalid = (state_q == ST_RD_I);
      d_rvalid = (state_q == ST_RD_D);
      i_rdata  = i_rvalid ? sram_rdata : '0;
      d_rdata  = d_rvalid ? sram_rdata : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// tb_sram_arbiter -- vector table plus scripted sequences against sram_arbiter with an SRAM model.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [3:0]  d_wen;
   logic [31:0] d_addr, d_wdata;
   logic        d_ack, d_rvalid;
   logic [31:0] d_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata = 32'h0;

   sram_arbiter #(.STARVE_MAX(4), .AW(32)) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // SRAM model driven purely by the DUT's SRAM port; ref_mem is the bench's own expectation.
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_wen == 4'b0000) begin
            sram_rdata <= mem[sram_addr[9:2]];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
         end
      end
   end

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] data;
   } exp_t;

   exp_t iq[$];
   exp_t dq[$];

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_zero();
      chk("rst_i_ack", 32'(i_ack), 0);
      chk("rst_d_ack", 32'(d_ack), 0);
      chk("rst_i_rvalid", 32'(i_rvalid), 0);
      chk("rst_d_rvalid", 32'(d_rvalid), 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_sram_en", 32'(sram_en), 0);
      chk("rst_sram_wen", 32'(sram_wen), 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_wdata", sram_wdata, 0);
   endtask

   // One clock: compare at the falling edge, then advance past the rising edge.
   task automatic step(input logic e_iack, input logic e_dack);
      exp_t e;
      @(negedge clk);
      if (iq.size() > 0 && iq[0].due == cyc) begin
         e = iq.pop_front();
         chk("i_rvalid", 32'(i_rvalid), 1);
         chk("i_rdata", i_rdata, e.data);
      end else begin
         chk("i_rvalid_idle", 32'(i_rvalid), 0);
         chk("i_rdata_idle", i_rdata, 0);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
         e = dq.pop_front();
         chk("d_rvalid", 32'(d_rvalid), 1);
         chk("d_rdata", d_rdata, e.data);
      end else begin
         chk("d_rvalid_idle", 32'(d_rvalid), 0);
         chk("d_rdata_idle", d_rdata, 0);
      end
      chk("i_ack", 32'(i_ack), 32'(e_iack));
      chk("d_ack", 32'(d_ack), 32'(e_dack));
      chk("sram_en", 32'(sram_en), 32'(e_iack | e_dack));
      if (e_dack) begin
         chk("sram_addr_d", sram_addr, d_addr);
         chk("sram_wen_d", 32'(sram_wen), 32'(d_wen));
         chk("sram_wdata_d", sram_wdata, d_wdata);
         if (d_wen == 4'b0000) begin
            dq.push_back('{due: cyc + 1, data: ref_mem[d_addr[9:2]]});
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (d_wen[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
         end
      end else if (e_iack) begin
         chk("sram_addr_i", sram_addr, i_addr);
         chk("sram_wen_i", 32'(sram_wen), 0);
         iq.push_back('{due: cyc + 1, data: ref_mem[i_addr[9:2]]});
      end else begin
         chk("sram_wen_idle", 32'(sram_wen), 0);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct packed {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic [3:0]  dwen;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        exp_iack;
      logic        exp_dack;
   } vec_t;

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [3:0] dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic ei, input logic ed);
      vec_t v;
      v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwen = dw; v.daddr = da; v.dwdata = dd;
      v.exp_iack = ei; v.exp_dack = ed;
      return v;
   endfunction

   localparam int NV = 15;
   vec_t vecs [NV];

   initial begin
      for (int k = 0; k < 256; k++) begin
         mem[k]     = {8'hC0, 8'h00, 8'(k), ~8'(k)};
         ref_mem[k] = {8'hC0, 8'h00, 8'(k), ~8'(k)};
      end
      mem[0]     = 32'h3C08_0001;
      ref_mem[0] = 32'h3C08_0001;

      //               ireq iaddr          dreq wen      daddr        wdata          iack dack
      vecs[0]  = mk(1, 32'hBFC0_0000, 0, 4'b0000, 32'h0,     32'h0,         1, 0);
      vecs[1]  = mk(0, 32'h0,         0, 4'b0000, 32'h0,     32'h0,         0, 0);
      vecs[2]  = mk(1, 32'h0000_0004, 1, 4'b0000, 32'h100,   32'h0,         0, 1);
      vecs[3]  = mk(1, 32'h0000_0004, 0, 4'b0000, 32'h0,     32'h0,         1, 0);
      vecs[4]  = mk(0, 32'h0,         0, 4'b0000, 32'h0,     32'h0,         0, 0);
      vecs[5]  = mk(0, 32'h0,         1, 4'b0011, 32'h200,   32'hDEAD_BEEF, 0, 1);
      vecs[6]  = mk(0, 32'h0,         0, 4'b0000, 32'h0,     32'h0,         0, 0);
      vecs[7]  = mk(0, 32'h0,         1, 4'b0000, 32'h200,   32'h0,         0, 1);
      vecs[8]  = mk(0, 32'h0,         1, 4'b0000, 32'h0,     32'h0,         0, 1);
      vecs[9]  = mk(0, 32'h0,         1, 4'b0000, 32'h4,     32'h0,         0, 1);
      vecs[10] = mk(0, 32'h0,         1, 4'b0000, 32'h8,     32'h0,         0, 1);
      vecs[11] = mk(0, 32'h0,         0, 4'b0000, 32'h0,     32'h0,         0, 0);
      vecs[12] = mk(1, 32'h0000_0020, 1, 4'b1111, 32'h10,    32'h1234_5678, 0, 1);
      vecs[13] = mk(1, 32'h0000_0020, 0, 4'b0000, 32'h0,     32'h0,         1, 0);
      vecs[14] = mk(0, 32'h0,         0, 4'b0000, 32'h0,     32'h0,         0, 0);

      // Reset held with requests active: everything must read 0.
      resetn = 1'b0;
      i_req = 1'b1; i_addr = 32'hFFFF_FFFC;
      d_req = 1'b1; d_wen = 4'hF; d_addr = 32'h0000_0040; d_wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      check_zero();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      i_req = 1'b0; d_req = 1'b0; d_wen = 4'h0;

      for (int v = 0; v < NV; v++) begin
         i_req   = vecs[v].ireq;
         i_addr  = vecs[v].iaddr;
         d_req   = vecs[v].dreq;
         d_wen   = vecs[v].dwen;
         d_addr  = vecs[v].daddr;
         d_wdata = vecs[v].dwdata;
         step(vecs[v].exp_iack, vecs[v].exp_dack);
      end

      // Sustained contention for ten cycles.
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_wen = 4'b0000; d_addr = 32'h44;
      for (int k = 0; k < 10; k++) begin
         logic ei;
`ifdef SRAM_ARB_FAIR_EN
         ei = ((k % 5) == 4);
`else
         ei = 1'b0;
`endif
         step(ei, !ei);
      end
      i_req = 1'b0; d_req = 1'b0;
      step(0, 0);

      // Reset asserted in the cycle the read data would return.
      d_req = 1'b1; d_wen = 4'b0000; d_addr = 32'h8;
      step(0, 1);
      resetn = 1'b0;
      i_req  = 1'b1;
      @(negedge clk);
      check_zero();
      iq.delete();
      dq.delete();
      @(posedge clk);
      #1;
      cyc++;
      resetn = 1'b1;
      i_req = 1'b0; d_req = 1'b0;
      step(0, 0);
      d_req = 1'b1; d_addr = 32'h4;
      step(0, 1);
      d_req = 1'b0;
      step(0, 0);
      step(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while instruction request waits (fairness build only).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 SHALL have resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have i_req  in  1  instruction fetch request; i_addr  in  AW  fetch address.
REQ-006 SHALL have i_ack  out  1  fetch accepted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  32  fetch data.
REQ-007 SHALL have d_req  in  1  data request; d_wen  in  4  byte write enables (0 = read); d_addr  in  AW; d_wdata  in  32.
REQ-008 SHALL have d_ack  out  1  data accepted; d_rvalid  out  1  load data valid; d_rdata  out  32  load data.
REQ-009 SHALL have sram_en  out  1; sram_wen  out  4; sram_addr  out  AW; sram_wdata  out  32; sram_rdata  in  32 (single shared synchronous SRAM, read data one cycle after sram_en).

Function
REQ-010 SHALL grant at most one requester per cycle; the grant is combinational from the current-cycle requests and state.
REQ-011 SHALL drive sram_en=1, sram_addr/sram_wen/sram_wdata from the granted requester, and the matching ack=1, in the grant cycle; with no grant, sram_en=0, sram_wen=0, both acks 0.
REQ-012 SHALL give data priority over instruction when both request (default rule).
REQ-013 SHALL force sram_wen=0 for instruction grants.
REQ-014 SHALL hold an owner FSM: IDLE, RD_I, RD_D; a granted read (instruction, or data with d_wen=0) moves to RD_I/RD_D; a granted write or no grant moves to IDLE.
REQ-015 SHALL, in RD_I, assert i_rvalid=1 and i_rdata=sram_rdata; in RD_D, assert d_rvalid=1 and d_rdata=sram_rdata; each rvalid is a one-cycle pulse.
REQ-016 SHALL allow a new grant in the same cycle as an rvalid (back-to-back reads, one read per cycle throughput, latency 1).
REQ-017 SHALL hold i_rdata/d_rdata at 0 when the corresponding rvalid is 0.
REQ-018 SHALL require requesters to hold req and payload stable until ack; a request dropped before ack is not served.
REQ-019 SHALL never produce an ack without sram_en in the same cycle, nor an rvalid without a prior-cycle read grant to that requester.

Reset
REQ-020 SHALL, while resetn=0, force the FSM to IDLE, starvation counter to 0, and all outputs to 0 (acks, rvalids, rdata, sram_en, sram_wen, sram_addr, sram_wdata).
REQ-021 SHALL discard a read outstanding at reset assertion: no rvalid in the first cycle after resetn rises.

Configuration
REQ-022 SHALL use macro SRAM_ARB_FAIR_EN: when defined, a counter increments on each data grant while i_req=1 and clears on any instruction grant or when i_req=0; at count==STARVE_MAX the next contended cycle grants instruction.
REQ-023 SHALL, without SRAM_ARB_FAIR_EN, contain no counter and apply strict data priority (REQ-012) unconditionally.

Structure
REQ-024 SHALL take the FSM state encoding and SRAM width constants from the shared CPU package (sram_arb_pkg).
REQ-025 SHALL be a single module; no sub-module (the fairness counter is inline, guarded by the macro).

Verification
REQ-026 Single fetch: i_req=1, i_addr=0xBFC00000, SRAM returns 0x3C080001 -> i_ack in cycle N, i_rvalid=1, i_rdata=0x3C080001 in N+1.
REQ-027 Contention: i_req=d_req=1, d_wen=0, d_addr=0x100 -> d_ack cycle N, i_ack=0; i_ack in N+1; d_rvalid N+1, i_rvalid N+2.
REQ-028 Store: d_req=1, d_wen=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF -> sram_wen=0011, sram_wdata=0xDEADBEEF, d_ack=1, no d_rvalid next cycle.
REQ-029 Fairness (SRAM_ARB_FAIR_EN, STARVE_MAX=4): i_req and d_req held 1 for 10 cycles -> grants D,D,D,D,I repeating; without macro -> ten data grants, no i_ack.
REQ-030 Reset mid-read: data read granted cycle N, resetn=0 during N+1 -> d_rvalid=0, all outputs 0, FSM IDLE after release.
REQ-031 Back-to-back reads: d_req held, addresses 0x0,0x4,0x8 -> d_ack three consecutive cycles, d_rvalid three consecutive cycles with matching data.
